// File: rtl/resolution_overlay_ctrl_pkg.sv
// Shared video defines: mode descriptor, mode ids, overlay defaults.
// Imported by the resolution overlay sequencer and its row tracker.
package resolution_overlay_ctrl_pkg;

  localparam int RESLINE_SIZE = 8;
  localparam int RES_OVL_X0   = 16;
  localparam int RES_OVL_Y0   = 16;

  typedef struct packed {
    logic [3:0]  id;
    logic [11:0] h_active;
    logic [11:0] v_active;
  } VideoMode;

  localparam logic [3:0] MODE_640X480  = 4'd0;
  localparam logic [3:0] MODE_800X600  = 4'd1;
  localparam logic [3:0] MODE_1024X768 = 4'd2;
  localparam logic [3:0] MODE_1280X720 = 4'd3;

endpackage

// File: rtl/resolution_row_tracker.sv
// Tracks which ROM row and vertical replicate the raster is on.
// Advances once per line at hpos==0 inside the overlay window.
module resolution_row_tracker
  import resolution_overlay_ctrl_pkg::*;
#(
  parameter int POS_W = 12,
  parameter int Y0    = RES_OVL_Y0,
  parameter int SCALE = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [POS_W-1:0] hpos,
  input  logic [POS_W-1:0] vpos,
  input  logic             frame_start,
  output logic [3:0]       row,
  output logic             in_win
);

  localparam logic [POS_W-1:0] Y0_P    = POS_W'(Y0);
  localparam logic [1:0]       SUB_MAX = 2'(SCALE - 1);

  logic [1:0] sub;

  always_ff @(posedge clock) begin
    if (reset) begin
      row    <= '0;
      sub    <= '0;
      in_win <= 1'b0;
    end else if (frame_start) begin
      in_win <= 1'b0;
    end else if (hpos == '0) begin
      if (vpos == Y0_P) begin
        row    <= '0;
        sub    <= '0;
        in_win <= 1'b1;
      end else if (in_win) begin
        if (sub == SUB_MAX) begin
          sub <= '0;
          if (row == 4'd15) in_win <= 1'b0;
          else              row    <= row + 4'd1;
        end else begin
          sub <= sub + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/resolution_overlay_ctrl.sv
// Prefetches one resolution-label ROM row per line and shifts it
// onto the raster as a 1-bit overlay mask with pixel replication.
module resolution_overlay_ctrl
  import resolution_overlay_ctrl_pkg::*;
#(
  parameter int LINE_W = RESLINE_SIZE,
  parameter int POS_W  = 12,
  parameter int X0     = RES_OVL_X0,
  parameter int Y0     = RES_OVL_Y0,
  parameter int SCALE  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  VideoMode          videoMode,
  input  logic [POS_W-1:0]  hpos,
  input  logic [POS_W-1:0]  vpos,
  input  logic              active,
  input  logic              frame_start,
  output logic [3:0]        rom_addr,
  input  logic [LINE_W-1:0] rom_q,
  output logic              pixel_on,
  output logic              overlay_de
);

  localparam int CNT_W = $clog2(LINE_W + 1);

  localparam logic [POS_W-1:0] H_TRIG  = POS_W'(X0 - 4);
  localparam logic [POS_W-1:0] H_LAST  = POS_W'(X0 - 1);
  localparam logic [1:0]       REP_MAX = 2'(SCALE - 1);
  localparam logic [CNT_W-1:0] BIT_MAX = CNT_W'(LINE_W - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_Q, WAIT_X, SHIFT
  } state_t;

  state_t            state, state_n;
  logic [3:0]        addr_n;
  logic [LINE_W-1:0] shreg, shreg_n;
  logic [CNT_W-1:0]  bitcnt, bitcnt_n;
  logic [1:0]        rep, rep_n;
  logic              blank;
  logic [3:0]        prev_id;
  logic              mode_chg;
  logic [3:0]        row;
  logic              in_win;
  logic              unused_mode;

  assign unused_mode = ^{videoMode.h_active, videoMode.v_active};
  assign mode_chg    = videoMode.id != prev_id;

  resolution_row_tracker #(
    .POS_W (POS_W),
    .Y0    (Y0),
    .SCALE (SCALE)
  ) u_rows (
    .clock       (clock),
    .reset       (reset),
    .hpos        (hpos),
    .vpos        (vpos),
    .frame_start (frame_start),
    .row         (row),
    .in_win      (in_win)
  );

  always_comb begin
    state_n  = state;
    addr_n   = rom_addr;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    rep_n    = rep;
    unique case (state)
      IDLE: begin
        if (in_win && active && !blank
            && hpos == H_TRIG) begin
          state_n = FETCH;
          addr_n  = row;
        end
      end
      FETCH: state_n = WAIT_Q;
      WAIT_Q: begin
        state_n  = WAIT_X;
        shreg_n  = rom_q;
        bitcnt_n = '0;
        rep_n    = '0;
      end
      WAIT_X: begin
        if (hpos == H_LAST) state_n = SHIFT;
      end
      SHIFT: begin
        if (rep == REP_MAX) begin
          rep_n    = '0;
          shreg_n  = shreg << 1;
          bitcnt_n = bitcnt + 1'b1;
          if (bitcnt == BIT_MAX) state_n = IDLE;
        end else begin
          rep_n = rep + 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    // a mode change or leaving the active region kills the line
    if (mode_chg || (state != IDLE && !active))
      state_n = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      rom_addr <= '0;
      shreg    <= '0;
      bitcnt   <= '0;
      rep      <= '0;
      blank    <= 1'b1;
      prev_id  <= videoMode.id;
    end else begin
      state    <= state_n;
      rom_addr <= addr_n;
      shreg    <= shreg_n;
      bitcnt   <= bitcnt_n;
      rep      <= rep_n;
      prev_id  <= videoMode.id;
      if (mode_chg)         blank <= 1'b1;
      else if (frame_start) blank <= 1'b0;
    end
  end

  assign overlay_de = state == SHIFT;
  assign pixel_on   = overlay_de & shreg[LINE_W-1];

endmodule

// File: tb/tb_resolution_overlay_ctrl.sv
// Drives a small raster into two overlay sequencers (SCALE 2 and 1)
// and compares every pixel against a window/bitmap reference.
module tb_resolution_overlay_ctrl;
  import resolution_overlay_ctrl_pkg::*;

  localparam int LW    = 8;
  localparam int PW    = 12;
  localparam int X0    = 16;
  localparam int Y0    = 16;
  localparam int H_TOT = 48;
  localparam int H_ACT = 40;
  localparam int V_TOT = 56;
  localparam int V_ACT = 50;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          active = 1'b0;
  logic          frame_start = 1'b0;
  logic [PW-1:0] hpos = '0;
  logic [PW-1:0] vpos = '0;
  VideoMode      mode = '0;
  logic [3:0]    addr2, addr1;
  logic [LW-1:0] q2, q1;
  logic          on2, on1, de2, de1;
  logic [LW-1:0] rom [16];

  int   n_assert = 0;
  int   n_fail   = 0;
  int   hh = 0;
  int   vv = V_TOT - 3;
  bit   fs_mask  = 1'b0;
  bit   dead     = 1'b0;
  bit   blank_m  = 1'b1;
  bit   rst_prev = 1'b0;
  logic [3:0] cur_id  = '0;
  logic [3:0] last_id = '0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    q2 <= rom[addr2];
    q1 <= rom[addr1];
  end

  resolution_overlay_ctrl #(
    .LINE_W(LW), .POS_W(PW), .X0(X0), .Y0(Y0), .SCALE(2)
  ) u_dut2 (
    .clock(clock), .reset(reset), .videoMode(mode),
    .hpos(hpos), .vpos(vpos), .active(active),
    .frame_start(frame_start), .rom_addr(addr2), .rom_q(q2),
    .pixel_on(on2), .overlay_de(de2)
  );

  resolution_overlay_ctrl #(
    .LINE_W(LW), .POS_W(PW), .X0(X0), .Y0(Y0), .SCALE(1)
  ) u_dut1 (
    .clock(clock), .reset(reset), .videoMode(mode),
    .hpos(hpos), .vpos(vpos), .active(active),
    .frame_start(frame_start), .rom_addr(addr1), .rom_q(q1),
    .pixel_on(on1), .overlay_de(de1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s v=%0d h=%0d observed=%0h expected=%0h",
             tag, vpos, hpos, obs, exp);
    end
  endtask

  function automatic bit in_rows(input int s, input int v);
    return v >= Y0 && v < Y0 + 16 * s;
  endfunction

  // overlay is a 16 x LW bitmap blown up by s in both directions
  function automatic void model(input int s, input int h, input int v,
                                output logic on, output logic de);
    int r, k;
    de = !dead && !blank_m && in_rows(s, v)
         && h >= X0 && h < X0 + LW * s;
    on = 1'b0;
    if (de) begin
      r  = (v - Y0) / s;
      k  = (h - X0) / s;
      on = rom[r][LW-1-k];
    end
  endfunction

  task automatic cyc(input bit rst_i, input bit act_low);
    logic e_on, e_de;
    @(posedge clock);
    #1;
    hpos        = PW'(hh);
    vpos        = PW'(vv);
    active      = (hh < H_ACT && vv < V_ACT) && !act_low;
    frame_start = (hh == 0 && vv == 0) && !fs_mask;
    reset       = rst_i;
    mode.id     = cur_id;
    @(negedge clock);
    if (hh == 0) dead = 1'b0;
    model(2, hh, vv, e_on, e_de);
    chk("pixel_on_s2", 32'(on2), 32'(e_on));
    chk("overlay_de_s2", 32'(de2), 32'(e_de));
    model(1, hh, vv, e_on, e_de);
    chk("pixel_on_s1", 32'(on1), 32'(e_on));
    chk("overlay_de_s1", 32'(de1), 32'(e_de));
    if (hh == X0 - 3 && !dead && !blank_m) begin
      if (in_rows(2, vv)) chk("rom_addr_s2", 32'(addr2), 32'((vv - Y0) / 2));
      if (in_rows(1, vv)) chk("rom_addr_s1", 32'(addr1), 32'(vv - Y0));
    end
    if (rst_prev) begin
      chk("rst_addr_s2", 32'(addr2), 32'd0);
      chk("rst_addr_s1", 32'(addr1), 32'd0);
    end
    rst_prev = rst_i;
    if (rst_i || cur_id != last_id) begin
      dead    = 1'b1;
      blank_m = 1'b1;
    end else if (frame_start) begin
      blank_m = 1'b0;
    end
    if (act_low) dead = 1'b1;
    last_id = cur_id;
    hh++;
    if (hh == H_TOT) begin
      hh = 0;
      vv = (vv + 1) % V_TOT;
    end
  endtask

  task automatic run_to(input int v, input int h);
    int n = 0;
    while (!(vv == v && hh == h)) begin
      cyc(1'b0, 1'b0);
      n++;
      if (n > H_TOT * V_TOT + 10) begin
        n_fail++;
        $error("FAIL run_to_timeout target=%0d/%0d", v, h);
        break;
      end
    end
  endtask

  initial begin
    mode.h_active = 12'd640;
    mode.v_active = 12'd480;
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    rom[0] = 8'b1010_0001;

    repeat (3) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("reset_on_s2", 32'(on2), 32'd0);
    chk("reset_de_s2", 32'(de2), 32'd0);
    chk("reset_on_s1", 32'(on1), 32'd0);
    chk("reset_de_s1", 32'(de1), 32'd0);
    run_to(0, 0);

    cyc(1'b0, 1'b0);
    run_to(0, 0);

    cyc(1'b0, 1'b0);
    run_to(20, 20);
    cur_id = cur_id + 4'($urandom_range(1, 15));
    run_to(0, 0);

    cyc(1'b0, 1'b0);
    run_to(18, 24);
    cyc(1'b0, 1'b1);
    run_to(22, 20);
    cyc(1'b1, 1'b0);
    run_to(0, 0);

    fs_mask = 1'b1;
    cyc(1'b0, 1'b0);
    run_to(0, 0);
    fs_mask = 1'b0;

    cyc(1'b0, 1'b0);
    run_to(0, 0);
    repeat (4) cyc(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
